// File: rtl/bayer_mosaic.sv
// bayer_mosaic: Avalon-ST 24-bit RGB to 8-bit raw Bayer re-mosaic; non-video packets are re-serialised 3:1.
// Optional: define BAYER_MOSAIC_CTRL_CAPTURE_EN to take the line width from type-0xF control packets.
module bayer_mosaic #(
    parameter int unsigned WID       = 1920,
    parameter logic [1:0]  BAYER_PAT = 2'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] sink_data,
    input  logic        sink_valid,
    input  logic        sink_sop,
    input  logic        sink_eop,
    output logic        sink_ready,
    output logic [7:0]  source_data,
    output logic        source_valid,
    output logic        source_sop,
    output logic        source_eop,
    input  logic        source_ready,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] { IDLE, VIDEO, CTRL } state_e;

    localparam logic [15:0] WID_W = 16'(WID);

    state_e      state_q, state_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [15:0] width_q, width_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic [1:0]  sub_q, sub_d;
    logic [15:0] cbuf_q, cbuf_d;
    logic        ceop_q, ceop_d;
    logic [7:0]  dat_q, dat_d;
    logic        val_q, val_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
`ifdef BAYER_MOSAIC_CTRL_CAPTURE_EN
    logic        cap_f_q, cap_f_d;
    logic [1:0]  cap_n_q, cap_n_d;
    logic [15:0] cap_w_q, cap_w_d;
`endif

    logic        adv;
    logic        hold_sub;
    logic        acc;
    logic        xp;
    logic        yp;
    logic [15:0] weff;
    logic [7:0]  pix;

    assign adv        = !val_q || source_ready;
    assign hold_sub   = (state_q == CTRL) && (sub_q != 2'd0);
    assign sink_ready = adv && !hold_sub && !rst;
    assign acc        = sink_valid && sink_ready;
    assign weff       = (width_q == '0) ? WID_W : width_q;

    // Flipping the phase by the pattern bits reduces every mosaic order to RGGB
    assign xp = x_q[0] ^ BAYER_PAT[0];
    assign yp = y_q[0] ^ BAYER_PAT[1];

    always_comb begin
        pix = sink_data[7:0];
        if (xp ^ yp) begin
            pix = sink_data[15:8];
        end else if (!yp) begin
            pix = sink_data[23:16];
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        width_d = width_q;
        fcnt_d  = fcnt_q;
        sub_d   = sub_q;
        cbuf_d  = cbuf_q;
        ceop_d  = ceop_q;
        dat_d   = dat_q;
        val_d   = val_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
`ifdef BAYER_MOSAIC_CTRL_CAPTURE_EN
        cap_f_d = cap_f_q;
        cap_n_d = cap_n_q;
        cap_w_d = cap_w_q;
`endif
        if (adv) begin
            val_d = 1'b0;
            sop_d = 1'b0;
            eop_d = 1'b0;
        end

        if (hold_sub) begin
            if (adv) begin
                val_d = 1'b1;
                dat_d = (sub_q == 2'd1) ? cbuf_q[7:0] : cbuf_q[15:8];
                if (sub_q == 2'd2) begin
                    sub_d = 2'd0;
                    eop_d = ceop_q;
                    if (ceop_q) begin
                        state_d = IDLE;
                    end
                end else begin
                    sub_d = sub_q + 2'd1;
                end
            end
        end else if (acc) begin
            if (sink_sop) begin
                val_d   = 1'b1;
                sop_d   = 1'b1;
                eop_d   = sink_eop;
                dat_d   = {4'h0, sink_data[3:0]};
                x_d     = '0;
                y_d     = '0;
                sub_d   = 2'd0;
                state_d = sink_eop ? IDLE : ((sink_data[3:0] == 4'h0) ? VIDEO : CTRL);
`ifdef BAYER_MOSAIC_CTRL_CAPTURE_EN
                cap_f_d = (sink_data[3:0] == 4'hF);
                cap_n_d = 2'd0;
`endif
            end else begin
                unique case (state_q)
                    VIDEO: begin
                        val_d = 1'b1;
                        dat_d = pix;
                        if (sink_eop) begin
                            eop_d   = 1'b1;
                            fcnt_d  = fcnt_q + 16'd1;
                            x_d     = '0;
                            y_d     = '0;
                            state_d = IDLE;
                        end else if (x_q == weff - 16'd1) begin
                            x_d = '0;
                            y_d = y_q + 16'd1;
                        end else begin
                            x_d = x_q + 16'd1;
                        end
                    end
                    CTRL: begin
                        val_d  = 1'b1;
                        dat_d  = sink_data[7:0];
                        cbuf_d = sink_data[23:8];
                        ceop_d = sink_eop;
                        sub_d  = 2'd1;
`ifdef BAYER_MOSAIC_CTRL_CAPTURE_EN
                        // Width lives entirely in payload beats 1-2; beat 3 only has to be present
                        if (cap_f_q && (cap_n_q != 2'd3)) begin
                            if (cap_n_q == 2'd0) begin
                                cap_w_d[15:4] = {sink_data[3:0], sink_data[11:8], sink_data[19:16]};
                            end else if (cap_n_q == 2'd1) begin
                                cap_w_d[3:0] = sink_data[3:0];
                            end
                            cap_n_d = cap_n_q + 2'd1;
                        end
                        if (sink_eop && cap_f_q && (cap_n_q >= 2'd2)) begin
                            width_d = cap_w_q;
                        end
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            width_q <= WID_W;
            fcnt_q  <= '0;
            sub_q   <= '0;
            cbuf_q  <= '0;
            ceop_q  <= 1'b0;
            dat_q   <= '0;
            val_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
`ifdef BAYER_MOSAIC_CTRL_CAPTURE_EN
            cap_f_q <= 1'b0;
            cap_n_q <= '0;
            cap_w_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            width_q <= width_d;
            fcnt_q  <= fcnt_d;
            sub_q   <= sub_d;
            cbuf_q  <= cbuf_d;
            ceop_q  <= ceop_d;
            dat_q   <= dat_d;
            val_q   <= val_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
`ifdef BAYER_MOSAIC_CTRL_CAPTURE_EN
            cap_f_q <= cap_f_d;
            cap_n_q <= cap_n_d;
            cap_w_q <= cap_w_d;
`endif
        end
    end

    assign source_data  = dat_q;
    assign source_valid = val_q;
    assign source_sop   = sop_q;
    assign source_eop   = eop_q;
    assign frame_cnt    = fcnt_q;

endmodule

// File: tb/tb_bayer_mosaic.sv
// Bench for bayer_mosaic: two instances (RGGB and BGGR) share one stimulus stream; outputs are
// checked against a packet-level model driven by randomized traffic and backpressure.
module tb_bayer_mosaic;

    localparam int unsigned W0 = 4;

    typedef struct {
        logic [23:0] d;
        logic        sop;
        logic        eop;
        bit          pay;
    } ib_t;

    typedef struct {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } ob_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] sink_data;
    logic        sink_valid, sink_sop, sink_eop;
    logic        sink_ready, sink_ready3;
    logic        source_ready;
    logic [7:0]  d0, d3;
    logic        v0, v3, s0, s3, e0o, e3o;
    logic [15:0] fc0, fc3;

    bayer_mosaic #(.WID(W0), .BAYER_PAT(2'd0)) u_dut0 (
        .clk(clk), .rst(rst),
        .sink_data(sink_data), .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
        .sink_ready(sink_ready),
        .source_data(d0), .source_valid(v0), .source_sop(s0), .source_eop(e0o),
        .source_ready(source_ready), .frame_cnt(fc0)
    );

    bayer_mosaic #(.WID(W0), .BAYER_PAT(2'd3)) u_dut3 (
        .clk(clk), .rst(rst),
        .sink_data(sink_data), .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
        .sink_ready(sink_ready3),
        .source_data(d3), .source_valid(v3), .source_sop(s3), .source_eop(e3o),
        .source_ready(source_ready), .frame_cnt(fc3)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    ib_t         inq[$];
    ob_t         e0[$];
    ob_t         e3[$];
    logic [23:0] pay_q[$];

    int unsigned cur_w = W0;
    int unsigned exp_frames = 0;
    int unsigned rmode = 0;
    int unsigned vpct = 100;
    int unsigned gap = 0;
    bit          stalled = 1'b0;
    logic [9:0]  held0, held3;

    // Colour per 2x2 site, index [pattern][y*2+x]: 0=R 1=G 2=B
    int unsigned col_tbl [4][4] = '{'{0, 1, 1, 2}, '{1, 0, 2, 1}, '{1, 2, 0, 1}, '{2, 1, 1, 0}};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] pick(input logic [23:0] p, input int unsigned c);
        case (c)
            0:       return p[23:16];
            1:       return p[15:8];
            default: return p[7:0];
        endcase
    endfunction

    task automatic push_in(input logic [23:0] d, input logic sop, input logic eop, input bit pay);
        ib_t b;
        b.d = d; b.sop = sop; b.eop = eop; b.pay = pay;
        inq.push_back(b);
    endtask

    task automatic push_out(input logic [7:0] a, input logic [7:0] b, input logic sop, input logic eop);
        ob_t o;
        o.sop = sop; o.eop = eop;
        o.d = a; e0.push_back(o);
        o.d = b; e3.push_back(o);
    endtask

    task automatic add_video(input int unsigned npix, input bit with_eop);
        logic [23:0] hdr, p;
        int unsigned w, xx, yy;
        logic last;
        hdr = 24'($urandom);
        hdr[3:0] = 4'h0;
        push_in(hdr, 1'b1, 1'b0, 1'b0);
        push_out(8'h00, 8'h00, 1'b1, 1'b0);
        w = (cur_w == 0) ? W0 : cur_w;
        for (int unsigned i = 0; i < npix; i++) begin
            p = 24'($urandom);
            last = with_eop && (i == npix - 1);
            xx = (i % w) % 2;
            yy = (i / w) % 2;
            push_in(p, 1'b0, last, 1'b0);
            push_out(pick(p, col_tbl[0][yy*2+xx]), pick(p, col_tbl[3][yy*2+xx]), 1'b0, last);
        end
        if (with_eop) exp_frames++;
    endtask

    task automatic add_ctrl(input logic [3:0] typ, input int unsigned nbeats, input bit with_eop);
        logic [23:0] hdr, p;
        logic [23:0] b [3];
        logic last;
        hdr = 24'($urandom);
        hdr[3:0] = typ;
        push_in(hdr, 1'b1, 1'b0, 1'b0);
        push_out({4'h0, typ}, {4'h0, typ}, 1'b1, 1'b0);
        for (int unsigned j = 0; j < nbeats; j++) begin
            p = (pay_q.size() != 0) ? pay_q.pop_front() : 24'($urandom);
            if (j < 3) b[j] = p;
            last = with_eop && (j == nbeats - 1);
            push_in(p, 1'b0, last, 1'b1);
            push_out(p[7:0], p[7:0], 1'b0, 1'b0);
            push_out(p[15:8], p[15:8], 1'b0, 1'b0);
            push_out(p[23:16], p[23:16], 1'b0, last);
        end
`ifdef BAYER_MOSAIC_CTRL_CAPTURE_EN
        if (typ == 4'hF && with_eop && nbeats >= 3)
            cur_w = {16'h0, b[0][3:0], b[0][11:8], b[0][19:16], b[1][3:0]};
`endif
    endtask

    task automatic add_garbage(input int unsigned n);
        for (int unsigned j = 0; j < n; j++) push_in(24'($urandom), 1'b0, 1'($urandom), 1'b0);
    endtask

    task automatic directed_frame();
        logic [7:0] ex0 [8];
        logic [7:0] ex3 [8];
        logic [7:0] r, g, b;
        ex0 = '{8'h10, 8'h21, 8'h12, 8'h23, 8'h24, 8'h35, 8'h26, 8'h37};
        ex3 = '{8'h30, 8'h21, 8'h32, 8'h23, 8'h24, 8'h15, 8'h26, 8'h17};
        push_in(24'h000000, 1'b1, 1'b0, 1'b0);
        push_out(8'h00, 8'h00, 1'b1, 1'b0);
        for (int unsigned i = 0; i < 8; i++) begin
            r = 8'h10 + 8'(i);
            g = 8'h20 + 8'(i);
            b = 8'h30 + 8'(i);
            push_in({r, g, b}, 1'b0, i == 7, 1'b0);
            push_out(ex0[i], ex3[i], 1'b0, i == 7);
        end
        exp_frames++;
    endtask

    task automatic run(input int unsigned max_cyc);
        int unsigned cyc = 0;
        ob_t o;
        while ((inq.size() != 0 || e0.size() != 0) && cyc < max_cyc) begin
            @(negedge clk);
            case (rmode)
                0:       source_ready = 1'b1;
                1:       source_ready = 1'($urandom_range(0, 1));
                default: source_ready = !source_ready;
            endcase
            if (inq.size() != 0 && $urandom_range(0, 99) < vpct) begin
                sink_valid = 1'b1;
                sink_data  = inq[0].d;
                sink_sop   = inq[0].sop;
                sink_eop   = inq[0].eop;
            end else begin
                sink_valid = 1'b0;
                sink_data  = 24'($urandom);
                sink_sop   = 1'($urandom);
                sink_eop   = 1'($urandom);
            end
            #1;
            if (stalled) begin
                check("hold0", 32'({v0, s0, e0o, d0}), 32'({1'b1, held0}));
                check("hold3", 32'({v3, s3, e3o, d3}), 32'({1'b1, held3}));
            end
            if (gap != 0) begin
                check("ctrl_ready_low", 32'(sink_ready), 32'd0);
                gap--;
            end
            if (v0 && source_ready) begin
                if (e0.size() == 0 || e3.size() == 0) begin
                    check("extra_beat", 32'(e0.size()), 32'd1);
                end else begin
                    o = e0.pop_front();
                    check("out0", 32'({s0, e0o, d0}), 32'({o.sop, o.eop, o.d}));
                    o = e3.pop_front();
                    check("out3", 32'({v3, s3, e3o, d3}), 32'({1'b1, o.sop, o.eop, o.d}));
                end
            end
            stalled = v0 && !source_ready;
            held0 = {s0, e0o, d0};
            held3 = {s3, e3o, d3};
            if (sink_valid && sink_ready) begin
                if (inq[0].pay) gap = 2;
                void'(inq.pop_front());
            end
            cyc++;
        end
        if (inq.size() + e0.size() != 0) check("timeout", 32'(inq.size() + e0.size()), 32'd0);
        @(negedge clk);
        sink_valid = 1'b0;
        stalled = 1'b0;
        gap = 0;
    endtask

    task automatic check_frames(input string tag);
        check({tag, "_fc0"}, 32'(fc0), 32'(16'(exp_frames)));
        check({tag, "_fc3"}, 32'(fc3), 32'(16'(exp_frames)));
    endtask

    bit idle;
    bit we;

    initial begin
        rst = 1'b1;
        sink_valid = 1'b0; sink_data = '0; sink_sop = 1'b0; sink_eop = 1'b0;
        source_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_sink_ready0", 32'(sink_ready), 32'd0);
        check("rst_sink_ready3", 32'(sink_ready3), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out0", 32'({v0, s0, e0o, d0}), 32'd0);
        check("rst_out3", 32'({v3, s3, e3o, d3}), 32'd0);
        check_frames("rst");
        check("idle_sink_ready", 32'(sink_ready), 32'd1);

        rmode = 0; vpct = 100;
        directed_frame();
        run(200);
        check_frames("frame_rggb_bggr");

        pay_q = '{24'hC0B0A0};
        add_ctrl(4'hF, 1, 1'b1);
        run(200);
        #1;
        check("ctrl_ready_back", 32'(sink_ready), 32'd1);

        rmode = 2;
        directed_frame();
        run(400);
        check_frames("frame_toggle");

        rmode = 1; vpct = 70;
        add_video(5, 1'b0);
        add_video(4, 1'b1);
        run(1000);
        check_frames("mid_sop");

`ifdef BAYER_MOSAIC_CTRL_CAPTURE_EN
        rmode = 0; vpct = 100;
        pay_q = '{24'h000000, 24'h000002, 24'h000200};
        add_ctrl(4'hF, 3, 1'b1);
        add_video(4, 1'b1);
        run(400);
        check_frames("capture");
`endif

        idle = 1'b1;
        for (int unsigned k = 0; k < 40; k++) begin
            rmode = $urandom_range(0, 2);
            vpct  = $urandom_range(40, 100);
            if (idle && $urandom_range(0, 3) == 0) add_garbage($urandom_range(1, 3));
            we = ($urandom_range(0, 6) != 0);
            if ($urandom_range(0, 2) != 0) add_video($urandom_range(1, 20), we);
            else add_ctrl(4'($urandom_range(1, 15)), $urandom_range(1, 4), we);
            idle = we;
            run(4000);
        end
        check_frames("random");

        // Reset in the middle of a frame
        @(negedge clk);
        source_ready = 1'b1;
        sink_valid = 1'b1; sink_sop = 1'b1; sink_eop = 1'b0; sink_data = 24'h000000;
        @(negedge clk);
        sink_sop = 1'b0; sink_data = 24'h102030;
        @(negedge clk);
        sink_data = 24'h112131;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_sink_ready", 32'(sink_ready), 32'd0);
        sink_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out0", 32'({v0, s0, e0o, d0}), 32'd0);
        check("midrst_out3", 32'({v3, s3, e3o, d3}), 32'd0);
        check("midrst_fc0", 32'(fc0), 32'd0);
        check("midrst_fc3", 32'(fc3), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_frames = 0;
        cur_w = W0;
        rmode = 0; vpct = 100;
        directed_frame();
        run(200);
        check_frames("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
